// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
// pixel_sequencer : frame sequencer for the pixel controller
//   (reset pulses, store window, memory-set bursts, clear, done).
// Revision: 1.0
// ============================================================================
module pixel_sequencer (
    input  logic       clk,
    input  logic       nrst_x,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_n_pulse,
    input  logic [7:0] cfg_period,
    input  logic       cfg_comp_en_sel,
    input  logic [3:0] cfg_read_mem,
    input  logic       pix_end,
    input  logic       mem_set_done,
    input  logic       last_mem,
    output logic       pix_reset,
    output logic       pix_store,
    output logic       comp_en_sel,
    output logic       mem_set_en,
    output logic       mem_set_clr,
    output logic [3:0] read_mem,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STORE, S_WAIT_END, S_MEMSET, S_GAP, S_CLR, S_FIN
    } state_t;

    // Timeout fires when the counter would step onto 4095.
    localparam logic [11:0] c_to_last = 12'd4094;

    state_t      state_q, state_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [3:0]  pcnt_q, pcnt_d;
    logic [11:0] to_q, to_d;
    logic [3:0]  n_q, n_d;
    logic [7:0]  p_q, p_d;
    logic        comp_q, comp_d;
    logic [3:0]  rmem_q, rmem_d;
    logic        err_q, err_d;
    logic        pix_reset_q, pix_reset_d;
    logic        pix_store_q, pix_store_d;
    logic        mem_set_en_q, mem_set_en_d;
    logic        mem_set_clr_q, mem_set_clr_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [3:0]  w_n_eff;
    logic [7:0]  w_p_eff;

    assign w_n_eff = (cfg_n_pulse < 4'd2) ? 4'd2 : cfg_n_pulse;
    assign w_p_eff = (cfg_period  < 8'd2) ? 8'd2 : cfg_period;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        pcnt_d        = pcnt_q;
        to_d          = to_q;
        n_d           = n_q;
        p_d           = p_q;
        comp_d        = comp_q;
        rmem_d        = rmem_q;
        err_d         = err_q;
        pix_reset_d   = 1'b0;
        pix_store_d   = 1'b0;
        mem_set_en_d  = 1'b0;
        mem_set_clr_d = 1'b0;
        done_d        = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SETUP;
                        tmr_d   = 8'd0;
                        n_d     = w_n_eff;
                        p_d     = w_p_eff;
                        comp_d  = cfg_comp_en_sel;
                        rmem_d  = cfg_read_mem;
                        err_d   = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (tmr_q == 8'd1) begin
                        state_d     = S_STORE;
                        tmr_d       = 8'd0;
                        pcnt_d      = 4'd1;
                        pix_reset_d = 1'b1;
                        pix_store_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 8'd1;
                    end
                end
                S_STORE: begin
                    // pcnt_q counts pulses issued so far, including this cycle's.
                    if (pcnt_q == n_q) begin
                        state_d = S_WAIT_END;
                        to_d    = 12'd0;
                    end else begin
                        pix_store_d = 1'b1;
                        if (tmr_q == p_q - 8'd1) begin
                            pix_reset_d = 1'b1;
                            pcnt_d      = pcnt_q + 4'd1;
                            tmr_d       = 8'd0;
                        end else begin
                            tmr_d = tmr_q + 8'd1;
                        end
                    end
                end
                S_WAIT_END: begin
                    if (pix_end) begin
                        state_d      = S_MEMSET;
                        to_d         = 12'd0;
                        mem_set_en_d = 1'b1;
                    end else if (to_q == c_to_last) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + 12'd1;
                    end
                end
                S_MEMSET: begin
                    if (mem_set_done) begin
                        if (last_mem) begin
                            state_d       = S_CLR;
                            mem_set_clr_d = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else if (to_q == c_to_last) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        mem_set_en_d = 1'b1;
                        to_d         = to_q + 12'd1;
                    end
                end
                S_GAP: begin
                    state_d      = S_MEMSET;
                    to_d         = 12'd0;
                    mem_set_en_d = 1'b1;
                end
                S_CLR: begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge nrst_x) begin
        if (nrst_x) begin
            state_q       <= S_IDLE;
            tmr_q         <= 8'd0;
            pcnt_q        <= 4'd0;
            to_q          <= 12'd0;
            n_q           <= 4'd2;
            p_q           <= 8'd2;
            comp_q        <= 1'b0;
            rmem_q        <= 4'd0;
            err_q         <= 1'b0;
            pix_reset_q   <= 1'b0;
            pix_store_q   <= 1'b0;
            mem_set_en_q  <= 1'b0;
            mem_set_clr_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pcnt_q        <= pcnt_d;
            to_q          <= to_d;
            n_q           <= n_d;
            p_q           <= p_d;
            comp_q        <= comp_d;
            rmem_q        <= rmem_d;
            err_q         <= err_d;
            pix_reset_q   <= pix_reset_d;
            pix_store_q   <= pix_store_d;
            mem_set_en_q  <= mem_set_en_d;
            mem_set_clr_q <= mem_set_clr_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign pix_reset   = pix_reset_q;
    assign pix_store   = pix_store_q;
    assign comp_en_sel = comp_q;
    assign mem_set_en  = mem_set_en_q;
    assign mem_set_clr = mem_set_clr_q;
    assign read_mem    = rmem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pixel_sequencer : directed self-checking bench for pixel_sequencer.
// Revision: 1.0
// ============================================================================
module tb_pixel_sequencer;

    logic       clk = 1'b0;
    logic       nrst_x = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [3:0] cfg_n_pulse = 4'd0;
    logic [7:0] cfg_period = 8'd0;
    logic       cfg_comp_en_sel = 1'b0;
    logic [3:0] cfg_read_mem = 4'd0;
    logic       pix_end = 1'b0, mem_set_done = 1'b0, last_mem = 1'b0;
    logic       pix_reset, pix_store, comp_en_sel, mem_set_en, mem_set_clr;
    logic [3:0] read_mem;
    logic       busy, done, err;

    pixel_sequencer u_dut (
        .clk(clk), .nrst_x(nrst_x), .start(start), .abort(abort),
        .cfg_n_pulse(cfg_n_pulse), .cfg_period(cfg_period),
        .cfg_comp_en_sel(cfg_comp_en_sel), .cfg_read_mem(cfg_read_mem),
        .pix_end(pix_end), .mem_set_done(mem_set_done), .last_mem(last_mem),
        .pix_reset(pix_reset), .pix_store(pix_store), .comp_en_sel(comp_en_sel),
        .mem_set_en(mem_set_en), .mem_set_clr(mem_set_clr), .read_mem(read_mem),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-frame observations, cycle 1 = first cycle after start is sampled.
    int n_pulse, first_pulse, last_pulse, store_cyc, wait_c;
    int en_rise, fall_c, done_at, n_clr, clr_c, n_done, done_c, err_c, end_c;
    int gaps[$];
    int low_lens[$];
    logic       s1_busy, s1_comp, s1_err;
    logic [3:0] s1_rmem;
    logic [12:0] rst_snap;

    function automatic logic [12:0] outs();
        return {pix_reset, pix_store, comp_en_sel, mem_set_en, mem_set_clr,
                read_mem, busy, done, err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [3:0] n, input logic [7:0] p, input logic comp,
                             input logic [3:0] rm, input int end_dly, input int n_mem,
                             input int abort_at, input int rst_at, input int budget);
        logic prev_store, prev_en, prev_busy, prev_err;
        cfg_n_pulse = n; cfg_period = p; cfg_comp_en_sel = comp; cfg_read_mem = rm;
        start = 1'b1;
        n_pulse = 0; first_pulse = -1; last_pulse = -1; store_cyc = 0; wait_c = -1;
        en_rise = 0; fall_c = -1; done_at = -1; n_clr = 0; clr_c = -1;
        n_done = 0; done_c = -1; err_c = -1; end_c = -1;
        gaps.delete(); low_lens.delete();
        prev_store = pix_store; prev_en = mem_set_en; prev_busy = busy; prev_err = err;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; pix_end = 1'b0; mem_set_done = 1'b0; last_mem = 1'b0;
            if (c == 1) begin
                s1_busy = busy; s1_comp = comp_en_sel; s1_rmem = read_mem; s1_err = err;
            end
            if (c == 5) begin
                // config churn plus a stray start while busy: both must be ignored
                cfg_n_pulse = 4'd9; cfg_period = 8'd5; cfg_comp_en_sel = ~comp;
                cfg_read_mem = 4'd3; start = 1'b1;
            end
            if (c == rst_at) begin
                nrst_x = 1'b1; #1;
                rst_snap = outs();
                nrst_x = 1'b0;
                end_c = c;
                break;
            end
            if (pix_reset) begin
                if (n_pulse > 0) gaps.push_back(c - last_pulse);
                else first_pulse = c;
                last_pulse = c;
                n_pulse++;
            end
            if (pix_store) store_cyc++;
            if (prev_store && !pix_store) wait_c = c;
            if (end_dly >= 0 && wait_c >= 0 && c == wait_c + end_dly) pix_end = 1'b1;
            if (mem_set_en && !prev_en) begin
                if (en_rise > 0) low_lens.push_back(c - fall_c);
                en_rise++;
                done_at = c + 4;
            end
            if (!mem_set_en && prev_en) fall_c = c;
            if (c == done_at) begin
                mem_set_done = 1'b1;
                last_mem = (en_rise == n_mem);
            end
            if (mem_set_clr) begin n_clr++; clr_c = c; end
            if (done) begin n_done++; done_c = c; end
            if (err && !prev_err) err_c = c;
            if (c == abort_at) abort = 1'b1;
            if (prev_busy && !busy) begin end_c = c; break; end
            prev_store = pix_store; prev_en = mem_set_en; prev_busy = busy; prev_err = err;
        end
        start = 1'b0; abort = 1'b0; pix_end = 1'b0; mem_set_done = 1'b0; last_mem = 1'b0;
        if (end_c < 0) chk("frame_within_budget", 32'd0, 32'd1);
    endtask

    task automatic chk_full_frame(input string t, input logic comp, input logic [3:0] rm);
        chk({t, "_setup_busy"}, 32'(s1_busy), 32'd1);
        chk({t, "_setup_comp"}, 32'(s1_comp), 32'(comp));
        chk({t, "_setup_rmem"}, 32'(s1_rmem), 32'(rm));
        chk({t, "_n_pulse"}, n_pulse, 3);
        chk({t, "_first_pulse"}, first_pulse, 3);
        chk({t, "_gap0"}, gaps.size() > 0 ? gaps[0] : -1, 77);
        chk({t, "_gap1"}, gaps.size() > 1 ? gaps[1] : -1, 77);
        chk({t, "_store_cyc"}, store_cyc, 155);
        chk({t, "_store_fall"}, wait_c, 158);
        chk({t, "_en_bursts"}, en_rise, 6);
        chk({t, "_gap_count"}, low_lens.size(), 5);
        foreach (low_lens[i]) chk({t, "_gap_len"}, low_lens[i], 1);
        chk({t, "_n_clr"}, n_clr, 1);
        chk({t, "_clr_cyc"}, clr_c, 204);
        chk({t, "_n_done"}, n_done, 1);
        chk({t, "_done_cyc"}, done_c, 205);
        chk({t, "_idle_cyc"}, end_c, 206);
        chk({t, "_err_rise"}, err_c, -1);
        chk({t, "_rmem_held"}, 32'(read_mem), 32'(rm));
        chk({t, "_comp_held"}, 32'(comp_en_sel), 32'(comp));
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 nrst_x = 1'b1;
        #2 chk("reset_outputs_async", 32'(outs()), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs_clocked", 32'(outs()), 32'd0);
        #1 nrst_x = 1'b0;

        // N=3, P=77, six memory bursts, mid-frame cfg change and stray start
        run_frame(4'd3, 8'd77, 1'b1, 4'hA, 10, 6, -1, -1, 400);
        chk_full_frame("f1", 1'b1, 4'hA);

        // Degenerate cfg: 0 pulses / period 1 behave as 2 / 2
        run_frame(4'd0, 8'd1, 1'b0, 4'h6, 3, 1, -1, -1, 100);
        chk("f2_n_pulse", n_pulse, 2);
        chk("f2_first_pulse", first_pulse, 3);
        chk("f2_gap", gaps.size() > 0 ? gaps[0] : -1, 2);
        chk("f2_store_cyc", store_cyc, 3);
        chk("f2_no_gap_state", low_lens.size(), 0);
        chk("f2_clr_cyc", clr_c, 15);
        chk("f2_done_cyc", done_c, 16);
        chk("f2_idle_cyc", end_c, 17);

        // pix_end never comes: timeout 4095 cycles after WAIT_END entry
        run_frame(4'd2, 8'd4, 1'b1, 4'h2, -1, 1, -1, -1, 4300);
        chk("to_wait_entry", wait_c, 8);
        chk("to_err_cyc", err_c, 4103);
        chk("to_idle_cyc", end_c, 4103);
        chk("to_n_done", n_done, 0);
        chk("to_err_level", 32'(err), 32'd1);
        chk("to_cmds_low", 32'({pix_reset, pix_store, mem_set_en, mem_set_clr}), 32'd0);

        // abort together with start in IDLE: start ignored, err kept
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_err", 32'(err), 32'd1);

        // abort during MEMSET; the start also clears err
        run_frame(4'd2, 8'd2, 1'b0, 4'h4, 2, 6, 10, -1, 100);
        chk("ab_err_cleared", 32'(s1_err), 32'd0);
        chk("ab_en_rise", en_rise, 1);
        chk("ab_idle_cyc", end_c, 11);
        chk("ab_en_low", 32'(mem_set_en), 32'd0);
        chk("ab_n_clr", n_clr, 0);
        chk("ab_n_done", n_done, 0);
        chk("ab_err", 32'(err), 32'd0);

        // async reset during STORE, then an immediate full frame
        run_frame(4'd3, 8'd77, 1'b1, 4'h9, 10, 6, -1, 4, 100);
        chk("rst_pulse_seen", n_pulse, 1);
        chk("rst_outputs_zero", 32'(rst_snap), 32'd0);
        run_frame(4'd3, 8'd77, 1'b0, 4'h5, 10, 6, -1, -1, 400);
        chk_full_frame("f3", 1'b0, 4'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_sequencer.md
PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (25 MHz nominal).
REQ-002 SHALL have port: nrst_x  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: start  in  1  one-cycle pulse; begins a frame sequence, accepted in IDLE only.
REQ-004 SHALL have port: abort  in  1  level; forces return to IDLE.
REQ-005 SHALL have port: cfg_n_pulse  in  4  pixel-reset pulses per frame; values 0 and 1 are treated as 2.
REQ-006 SHALL have port: cfg_period  in  8  cycles between pix_reset rising edges; values 0 and 1 are treated as 2.
REQ-007 SHALL have port: cfg_comp_en_sel  in  1  comparator-enable select for the frame.
REQ-008 SHALL have port: cfg_read_mem  in  4  memory index driven to the pixel controller.
REQ-009 SHALL have ports: pix_end, mem_set_done, last_mem  in  1 each  status from pixel controller.
REQ-010 SHALL have ports: pix_reset, pix_store, comp_en_sel, mem_set_en, mem_set_clr  out  1 each  pixel-controller commands.
REQ-011 SHALL have port: read_mem  out  4  memory index.
REQ-012 SHALL have ports: busy, done, err  out  1 each  busy level; done one-cycle pulse; err sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, SETUP, STORE, WAIT_END, MEMSET, GAP, CLR, FIN.
REQ-014 SHALL latch all cfg_* inputs on the cycle start is accepted; mid-frame cfg changes SHALL have no effect.
REQ-015 IDLE + start -> SETUP; comp_en_sel and read_mem SHALL take latched values in SETUP and hold until the next accepted start.
REQ-016 SETUP SHALL last exactly 2 cycles, then -> STORE.
REQ-017 In STORE, pix_store SHALL be high from the first pix_reset pulse cycle through the last pix_reset pulse cycle inclusive, and low on the following cycle.
REQ-018 pix_reset SHALL be a one-cycle pulse, first on the STORE entry cycle, repeated every P cycles (P = effective period), N pulses total (N = effective count).
REQ-019 After the last pulse -> WAIT_END; on pix_end = 1 -> MEMSET.
REQ-020 MEMSET: mem_set_en SHALL be held high until mem_set_done is sampled high, then deasserted next cycle.
REQ-021 If last_mem is high in the same cycle as mem_set_done -> CLR; otherwise -> GAP (1 cycle, mem_set_en low) -> MEMSET.
REQ-022 CLR: mem_set_clr SHALL be high for exactly 1 cycle, then -> FIN.
REQ-023 FIN: done SHALL pulse for exactly 1 cycle, then -> IDLE.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 A 12-bit timeout counter SHALL run in WAIT_END and MEMSET, cleared on state entry; on reaching 4095 without the awaited input -> err = 1, all commands low, -> IDLE, no done.
REQ-026 err SHALL stay high until the next accepted start, which clears it.
REQ-027 abort high in any state SHALL drive pix_reset, pix_store, mem_set_en, mem_set_clr low on the next cycle and -> IDLE; done not pulsed; err unchanged.
REQ-028 abort and start in the same cycle: abort SHALL win, start ignored.
REQ-029 start while busy SHALL be ignored without side effect.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While nrst_x = 1, state SHALL be IDLE and all outputs 0 (read_mem = 4'd0), asynchronously.
REQ-032 nrst_x asserted mid-frame SHALL abandon the frame immediately; no done, no mem_set_clr pulse.
REQ-033 After nrst_x deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-034 N=3, P=77, start -> pix_reset pulses 77 cycles apart, pix_store high 155 cycles, then low.
REQ-035 pix_end after 10 cycles; mem_set_done 4 cycles after each mem_set_en rise; last_mem on 6th done -> 6 mem_set_en bursts, 1 GAP between each, one mem_set_clr, one done.
REQ-036 cfg_n_pulse=0, cfg_period=1 -> exactly 2 pix_reset pulses, 2 cycles apart.
REQ-037 pix_end never asserted -> err=1 4095 cycles after WAIT_END entry, busy=0, no done; next start clears err.
REQ-038 abort during MEMSET -> mem_set_en low next cycle, busy=0, no mem_set_clr, no done.
REQ-039 nrst_x pulsed during STORE -> all outputs 0 immediately; subsequent start runs full frame normally.
